// File: rtl/alu_share_arbiter.sv
// Round-robin share of one WIDTH-bit logic/arithmetic unit between two requesters.
// Latency: accept edge -> EXEC -> RESP; response held until rsp_ready, no new grant meanwhile.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic             winner;
    logic             any_valid;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             id_q;
    logic [WIDTH-1:0] alu_res;

    // On a tie the requester that did not win last time gets the unit.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            winner = ~last_grant;
        else
            winner = req1_valid;
    end

    assign req0_ready = (state == IDLE) && any_valid && !winner;
    assign req1_ready = (state == IDLE) && any_valid && winner;
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op_q)
            3'b000: alu_res = a_q & b_q;
            3'b001: alu_res = a_q | b_q;
            3'b010: alu_res = a_q ^ b_q;
            3'b011: alu_res = ~(a_q | b_q);
            3'b100: alu_res = a_q + b_q;
            3'b101: alu_res = a_q - b_q;
            3'b110: alu_res[0] = $signed(a_q) < $signed(b_q);
            default: alu_res = a_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_valid) begin
                op_q       <= winner ? req1_op : req0_op;
                a_q        <= winner ? req1_a  : req0_a;
                b_q        <= winner ? req1_b  : req0_b;
                id_q       <= winner;
                last_grant <= winner;
            end
            if (state == EXEC) begin
                rsp_result <= alu_res;
                rsp_zero   <= (alu_res == '0);
                rsp_id     <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: expected responses queued at grant, checked on rsp_valid.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [31:0] rsp_result;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic id, input logic [31:0] res);
        exp_t e;
        e.id   = id;
        e.res  = res;
        e.zero = (res == 32'h0);
        sb.push_back(e);
    endtask

    task automatic wait_grant(output int who, output int waited);
        who    = -1;
        waited = 0;
        while (who < 0 && waited < 20) begin
            if (req0_ready)      who = 0;
            else if (req1_ready) who = 1;
            else begin
                step();
                waited++;
            end
        end
        chk1("grant_seen", who >= 0, 1'b1);
    endtask

    task automatic expect_rsp(input string tag, output int lat);
        exp_t e;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        chk1({tag, "_valid"}, rsp_valid, 1'b1);
        chk1({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk1({tag, "_id"}, rsp_id, e.id);
            chk32({tag, "_result"}, rsp_result, e.res);
            chk1({tag, "_zero"}, rsp_zero, e.zero);
        end
    endtask

    logic [31:0] sweep_tab [8];
    int          who, waited, lat;
    logic        exp_id;

    initial begin
        sweep_tab[0] = 32'h0000_0000; sweep_tab[1] = 32'h8000_0001;
        sweep_tab[2] = 32'h8000_0001; sweep_tab[3] = 32'h7FFF_FFFE;
        sweep_tab[4] = 32'h8000_0001; sweep_tab[5] = 32'h7FFF_FFFF;
        sweep_tab[6] = 32'h0000_0001; sweep_tab[7] = 32'h8000_0000;

        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        rsp_ready  = 1;
        #2;
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rsp_id", rsp_id, 1'b0);
        chk32("rst_rsp_result", rsp_result, 32'h0);
        chk1("rst_rsp_zero", rsp_zero, 1'b0);
        step();
        rst = 0;

        // Single XOR request from requester 0
        req0_valid = 1; req0_op = 3'b010; req0_a = 32'hFFFF_0000; req0_b = 32'h0F0F_0F0F;
        #1;
        chk1("single_req0_ready", req0_ready, 1'b1);
        chk1("single_req1_ready", req1_ready, 1'b0);
        push(1'b0, 32'hF0F0_0F0F);
        step();
        req0_valid = 0;
        chk1("single_exec_busy", busy, 1'b1);
        chk1("single_exec_rsp_valid", rsp_valid, 1'b0);
        chk1("single_exec_ready", req0_ready, 1'b0);
        expect_rsp("single", lat);
        chk32("single_latency", lat, 32'd1);
        step();
        chk1("single_after_rsp_valid", rsp_valid, 1'b0);
        chk1("single_after_busy", busy, 1'b0);

        // Contention from reset: strict alternation, 3-cycle spacing
        rst = 1;
        step();
        rst = 0;
        req0_valid = 1; req0_op = 3'b100; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1;
        req1_valid = 1; req1_op = 3'b101; req1_a = 32'd5;         req1_b = 32'd7;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            wait_grant(who, waited);
            chk1("cont_winner", who == 1, exp_id);
            chk1("cont_single_ready", req0_ready & req1_ready, 1'b0);
            if (k > 0) chk32("cont_spacing_wait", waited, 32'd0);
            push(exp_id, exp_id ? 32'hFFFF_FFFE : 32'h0);
            step();
            chk1("cont_exec_ready", req0_ready | req1_ready, 1'b0);
            expect_rsp("cont", lat);
            chk32("cont_latency", lat, 32'd1);
            step();
        end
        req0_valid = 0; req1_valid = 0;

        // Backpressure: response held 4 cycles, no grants while pending
        req0_valid = 1; req0_op = 3'b001; req0_a = 32'h1234_0000; req0_b = 32'h0000_5678;
        rsp_ready  = 0;
        #1;
        wait_grant(who, waited);
        chk1("bp_winner", who == 0, 1'b1);
        push(1'b0, 32'h1234_5678);
        step();
        req0_valid = 0;
        req1_valid = 1; req1_op = 3'b000; req1_a = 32'hFF; req1_b = 32'h0F;
        step();
        for (int k = 0; k < 4; k++) begin
            chk1("bp_rsp_valid", rsp_valid, 1'b1);
            chk32("bp_rsp_result", rsp_result, 32'h1234_5678);
            chk1("bp_rsp_id", rsp_id, 1'b0);
            chk1("bp_req1_ready", req1_ready, 1'b0);
            chk1("bp_busy", busy, 1'b1);
            step();
        end
        rsp_ready = 1;
        expect_rsp("bp", lat);
        step();
        chk1("bp_idle_rsp_valid", rsp_valid, 1'b0);
        chk1("bp_idle_busy", busy, 1'b0);
        chk1("bp_idle_req1_ready", req1_ready, 1'b1);
        req1_valid = 0;
        #1;
        chk1("bp_drop_req1_ready", req1_ready, 1'b0);

        // Opcode sweep on requester 0
        for (int op = 0; op < 8; op++) begin
            step();
            req0_valid = 1; req0_op = op[2:0]; req0_a = 32'h8000_0000; req0_b = 32'h1;
            #1;
            wait_grant(who, waited);
            push(1'b0, sweep_tab[op]);
            step();
            req0_valid = 0;
            expect_rsp("sweep", lat);
        end
        step();

        // Operands changed after accept must not affect the result
        req1_valid = 1; req1_op = 3'b000; req1_a = 32'hFF; req1_b = 32'h0F;
        #1;
        wait_grant(who, waited);
        chk1("opchg_winner", who == 1, 1'b1);
        push(1'b1, 32'h0F);
        step();
        req1_valid = 0; req1_a = 0; req1_b = 0;
        expect_rsp("opchg", lat);
        step();

        // Asynchronous reset while a response is pending
        req1_valid = 1; req1_op = 3'b111; req1_a = 32'hDEAD_BEEF; req1_b = 32'h0;
        #1;
        wait_grant(who, waited);
        push(1'b1, 32'hDEAD_BEEF);
        step();
        req1_valid = 0;
        rsp_ready  = 0;
        step();
        chk1("mid_rsp_valid", rsp_valid, 1'b1);
        chk1("mid_rsp_id", rsp_id, 1'b1);
        #2;
        rst = 1;
        #1;
        chk1("arst_rsp_valid", rsp_valid, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk32("arst_rsp_result", rsp_result, 32'h0);
        chk1("arst_rsp_id", rsp_id, 1'b0);
        chk1("arst_rsp_zero", rsp_zero, 1'b0);
        sb.delete();
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        step();
        rst = 0;
        #1;
        chk1("arst_tie_req0_ready", req0_ready, 1'b1);
        chk1("arst_tie_req1_ready", req1_ready, 1'b0);
        req0_valid = 0; req1_valid = 0;
        chk32("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
